// File: rtl/payload_serializer.sv
`default_nettype none
// ============================================================================
// Module   : payload_serializer
// Purpose  : Buffers parallel IQ words (N_BYTES bytes each) in a small word
//            FIFO and streams them out one byte per beat on an AXI-Stream-
//            style interface. WORDS_PER_PKT words form one payload; m_tlast
//            marks the final byte. The upstream source cannot be stalled,
//            so words arriving at a full FIFO are dropped and counted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising edge
//   srst_n       in   asynchronous active-low reset
//   en           in   stream enable, only consulted when no packet is open
//   in_valid     in   input word strobe
//   in_data      in   [N_BYTES-1:0][BW_out-1:0] word, in_data[0] sent first
//   m_tdata      out  output byte
//   m_tvalid     out  output byte valid
//   m_tready     in   downstream ready
//   m_tlast      out  last byte of the payload
//   busy         out  packet open or FIFO non-empty
//   overflow_cnt out  dropped-word count, saturating
//   pkt_cnt      out  completed-packet count, wrapping
// ============================================================================
module payload_serializer #(
  parameter int BW_out        = 8,
  parameter int N_BYTES       = 9,
  parameter int WORDS_PER_PKT = 16,
  parameter int DEPTH         = 2
) (
  input  logic                            clk,
  input  logic                            srst_n,
  input  logic                            en,
  input  logic                            in_valid,
  input  logic [N_BYTES-1:0][BW_out-1:0]  in_data,
  output logic [BW_out-1:0]               m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic                            busy,
  output logic [15:0]                     overflow_cnt,
  output logic [15:0]                     pkt_cnt
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BYTE_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int WORD_W = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [BYTE_W-1:0] LAST_BYTE_C = BYTE_W'(N_BYTES - 1);
  localparam logic [WORD_W-1:0] LAST_WORD_C = WORD_W'(WORDS_PER_PKT - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Word FIFO storage; contents need no reset because m_tdata is gated by
  // the occupancy count.
  logic [N_BYTES-1:0][BW_out-1:0] mem [DEPTH];
  logic [N_BYTES-1:0][BW_out-1:0] head_word;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [BYTE_W-1:0] byte_idx;
  logic [WORD_W-1:0] word_idx;

  logic in_pkt;
  logic not_empty;
  logic has_room;
  logic gate_open;
  logic push;
  logic drop_full;
  logic beat_xfer;
  logic word_done;
  logic last_xfer;

  // --------------------------------------------------------------------------
  // Control decode. Room is judged on the pre-edge count only, so a pop in
  // the same cycle never frees a slot for the incoming word.
  // --------------------------------------------------------------------------
  always_comb begin
    in_pkt    = (state == ST_ACTIVE);
    not_empty = (count != '0);
    has_room  = (count < DEPTH_C);
    gate_open = in_pkt | en;
    push      = in_valid & has_room & gate_open;
    // A word turned away while idle with en=0 is not an overflow.
    drop_full = in_valid & ~has_room & gate_open;
    beat_xfer = not_empty & m_tready;
    word_done = beat_xfer & (byte_idx == LAST_BYTE_C);
    last_xfer = word_done & (word_idx == LAST_WORD_C);
  end

  // --------------------------------------------------------------------------
  // Packet state machine: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (push) begin
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (last_xfer) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage write
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy. Pointers wrap naturally (DEPTH is 2^n).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (word_done) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, word_done})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Byte / word position within the current payload
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      byte_idx <= '0;
      word_idx <= '0;
    end else if (beat_xfer) begin
      if (byte_idx == LAST_BYTE_C) begin
        byte_idx <= '0;
        if (word_idx == LAST_WORD_C) begin
          word_idx <= '0;
        end else begin
          word_idx <= word_idx + 1'b1;
        end
      end else begin
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Statistics counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      overflow_cnt <= '0;
      pkt_cnt      <= '0;
    end else begin
      if (drop_full && (overflow_cnt != 16'hFFFF)) begin
        overflow_cnt <= overflow_cnt + 16'd1;
      end
      if (last_xfer) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stream outputs. Everything here is a function of registered state only,
  // so data and last stay stable while the sink stalls.
  // --------------------------------------------------------------------------
  assign head_word = mem[rd_ptr];

  always_comb begin
    m_tvalid = not_empty;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    busy     = in_pkt | not_empty;
    if (not_empty) begin
      m_tdata = head_word[byte_idx];
      m_tlast = (word_idx == LAST_WORD_C) && (byte_idx == LAST_BYTE_C);
    end
  end

endmodule
`default_nettype wire
